// File: rtl/touch_led_ctrl.sv
// rtl/touch_led_ctrl.sv - touch key debounce, short/long press classification and LED mode sequencer
// Optional: define LED_ACTIVE_LOW_EN to drive the led port inverted for active-low LED wiring.
module touch_led_ctrl #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000,
    parameter int SLOW_HALF   = 25000000,
    parameter int FAST_HALF   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       touch_key,
    output logic       led,
    output logic [1:0] mode,
    output logic       press_pulse
);

    localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int SW = (SLOW_HALF   > 1) ? $clog2(SLOW_HALF)   : 1;
    localparam int FW = (FAST_HALF   > 1) ? $clog2(FAST_HALF)   : 1;
    localparam int BW = (SW > FW) ? SW : FW;

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES - 1);
    localparam logic [BW-1:0] SLOW_MAX = BW'(SLOW_HALF - 1);
    localparam logic [BW-1:0] FAST_MAX = BW'(FAST_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG_HELD
    } state_t;

    logic          sync1_q, sync2_q;
    logic [1:0]    vld_q, vld_d;
    logic          rel_seen_q, rel_seen_d;
    logic          key_db_q, key_db_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic          pulse_q, pulse_d;
    logic [1:0]    mode_prev_q, mode_prev_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          led_q, led_d;
    logic [BW-1:0] half_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            vld_q       <= 2'b00;
            rel_seen_q  <= 1'b0;
            key_db_q    <= 1'b0;
            deb_cnt_q   <= '0;
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            mode_q      <= 2'd0;
            pulse_q     <= 1'b0;
            mode_prev_q <= 2'd0;
            blink_cnt_q <= '0;
            led_q       <= 1'b0;
        end else begin
            sync1_q     <= touch_key;
            sync2_q     <= sync1_q;
            vld_q       <= vld_d;
            rel_seen_q  <= rel_seen_d;
            key_db_q    <= key_db_d;
            deb_cnt_q   <= deb_cnt_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            mode_q      <= mode_d;
            pulse_q     <= pulse_d;
            mode_prev_q <= mode_prev_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
        end
    end

    assign half_max = (mode_q == 2'd2) ? SLOW_MAX : FAST_MAX;

    always_comb begin
        vld_d       = {vld_q[0], 1'b1};
        rel_seen_d  = rel_seen_q;
        key_db_d    = key_db_q;
        deb_cnt_d   = '0;
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        mode_d      = mode_q;
        pulse_d     = 1'b0;
        mode_prev_d = mode_q;
        blink_cnt_d = '0;
        led_d       = led_q;

        // A key still held across reset must be seen released before it can start a press.
        if (vld_q[1] && !sync2_q && !key_db_q)
            rel_seen_d = 1'b1;

        if (sync2_q != key_db_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                key_db_d  = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (key_db_q && rel_seen_q) begin
                    state_d    = S_PRESSED;
                    hold_cnt_d = '0;
                end
            end
            S_PRESSED: begin
                // Release is tested before the long threshold so a tie counts as short.
                if (!key_db_q) begin
                    state_d = S_IDLE;
                    mode_d  = mode_q + 2'd1;
                    pulse_d = 1'b1;
                end else if (hold_cnt_q == LONG_MAX) begin
                    state_d = S_LONG_HELD;
                    mode_d  = 2'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_LONG_HELD: begin
                if (!key_db_q)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (mode_prev_q != mode_q) begin
            led_d = (mode_q != 2'd0);
        end else begin
            case (mode_q)
                2'd0: led_d = 1'b0;
                2'd1: led_d = 1'b1;
                default: begin
                    if (blink_cnt_q == half_max) begin
                        led_d = ~led_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign mode        = mode_q;
    assign press_pulse = pulse_q;

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~led_q;
`else
    assign led = led_q;
`endif

endmodule

// File: tb/tb_touch_led_ctrl.sv
// tb/tb_touch_led_ctrl.sv - directed vector bench for touch_led_ctrl
module tb_touch_led_ctrl;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       touch_key = 1'b0;
    logic       led;
    logic [1:0] mode;
    logic       press_pulse;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pulse_cnt = 0;

    touch_led_ctrl #(
        .DEB_CYCLES (4),
        .LONG_CYCLES(20),
        .SLOW_HALF  (8),
        .FAST_HALF  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .touch_key  (touch_key),
        .led        (led),
        .mode       (mode),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_pulse === 1'b1)
            pulse_cnt = pulse_cnt + 1;
    end

    typedef struct {
        string      name;
        int         hold;
        logic [1:0] exp_mode;
        int         exp_pulses;
        bit         chk_led;
        logic       exp_led;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act === exp)
            pass_cnt = pass_cnt + 1;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int n);
        touch_key = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        touch_key = 1'b0;
    endtask

    task automatic wait_mode(input logic [1:0] m, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1;
            if (mode === m)
                found = 1'b1;
        end
        check({name, "_reached"}, 32'(found), 32'd1);
        if (found)
            check({name, "_pulse_with_mode"}, 32'(press_pulse), 32'd1);
    endtask

    initial begin
        int base;

        vecs[0]  = '{"glitch3",     3, 2'd0, 0, 1'b1, 1'b0};
        vecs[1]  = '{"short10",    10, 2'd1, 1, 1'b1, 1'b1};
        vecs[2]  = '{"short_min4",  4, 2'd2, 1, 1'b0, 1'b0};
        vecs[3]  = '{"tie20_short",20, 2'd3, 1, 1'b0, 1'b0};
        vecs[4]  = '{"long21",     21, 2'd0, 0, 1'b1, 1'b0};
        vecs[5]  = '{"short6",      6, 2'd1, 1, 1'b1, 1'b1};
        vecs[6]  = '{"short5",      5, 2'd2, 1, 1'b0, 1'b0};
        vecs[7]  = '{"long40",     40, 2'd0, 0, 1'b1, 1'b0};
        vecs[8]  = '{"seq_m1",      7, 2'd1, 1, 1'b1, 1'b1};
        vecs[9]  = '{"seq_m2",      7, 2'd2, 1, 1'b0, 1'b0};
        vecs[10] = '{"seq_m3",      7, 2'd3, 1, 1'b0, 1'b0};
        vecs[11] = '{"seq_wrap0",   7, 2'd0, 1, 1'b1, 1'b0};

        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_led", 32'(led), 32'(INV));
        check("reset_pulse", 32'(press_pulse), 32'd0);
        cycles(5);

        for (int v = 0; v < 12; v++) begin
            base = pulse_cnt;
            press(vecs[v].hold);
            cycles(14);
            check({vecs[v].name, "_mode"}, 32'(mode), 32'(vecs[v].exp_mode));
            check({vecs[v].name, "_pulses"}, 32'(pulse_cnt - base), 32'(vecs[v].exp_pulses));
            if (vecs[v].chk_led)
                check({vecs[v].name, "_led"}, 32'(led), 32'(vecs[v].exp_led ^ INV));
        end

        // Slow blink: high for 8 cycles starting the cycle after mode changes.
        press(7);
        cycles(14);
        press(7);
        wait_mode(2'd2, "slow");
        for (int k = 0; k < 24; k++) begin
            cycles(1);
            check($sformatf("slow_led_%0d", k), 32'(led), 32'((((k / 8) % 2) == 0) ^ INV));
        end

        press(7);
        wait_mode(2'd3, "fast");
        for (int k = 0; k < 12; k++) begin
            cycles(1);
            check($sformatf("fast_led_%0d", k), 32'(led), 32'((((k / 2) % 2) == 0) ^ INV));
        end

        // Reset while a press is in progress; the held key must be ignored afterwards.
        touch_key = 1'b1;
        cycles(10);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midrst_mode", 32'(mode), 32'd0);
        check("midrst_led", 32'(led), 32'(INV));
        check("midrst_pulse", 32'(press_pulse), 32'd0);
        base = pulse_cnt;
        cycles(10);
        touch_key = 1'b0;
        cycles(20);
        check("held_ignored_mode", 32'(mode), 32'd0);
        check("held_ignored_pulses", 32'(pulse_cnt - base), 32'd0);
        check("held_ignored_led", 32'(led), 32'(INV));

        base = pulse_cnt;
        press(7);
        cycles(14);
        check("repress_mode", 32'(mode), 32'd1);
        check("repress_pulses", 32'(pulse_cnt - base), 32'd1);
        check("repress_led", 32'(led), 32'(1'b1 ^ INV));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/touch_led_ctrl.md
Name: touch_led_ctrl

Overview:
Mode controller for the touch-key/LED path on the board.
- Synchronises and debounces the raw touch_key input.
- Classifies each touch as short or long press.
- Sequences the LED through four modes: off, on, slow blink, fast blink.
- Replaces the bare edge-toggle LED logic; exposes the current mode and a press-event strobe for other blocks.

Parameters:
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a new key level (20 ms at 50 MHz)
LONG_CYCLES, 50000000, debounced-high cycles that qualify a press as long (1 s)
SLOW_HALF, 25000000, half-period of slow blink in cycles
FAST_HALF, 5000000, half-period of fast blink in cycles

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is synchronous and active-high
touch_key  input  1  raw touch sensor output, asynchronous, high = touched
led  output  1  LED drive
mode  output  2  current mode: 0 off, 1 on, 2 slow blink, 3 fast blink
press_pulse  output  1  one-cycle strobe on every accepted short press

Behaviour:
- Reset (rst high at a clk edge) clears all state:
  - sync flops = 0, key_db = 0, FSM = IDLE, all counters = 0.
  - mode = 0, press_pulse = 0, led = 0 (see optional feature).
  - Reset mid-press or mid-blink aborts immediately; no event is generated.
- Sync: 2-flop synchroniser on touch_key; key_s is the second-stage output.
- Debounce:
  - deb_cnt counts while key_s != key_db and clears whenever key_s == key_db.
  - When deb_cnt reaches DEB_CYCLES-1 with key_s still different, key_db <= key_s and deb_cnt <= 0.
  - Total latency from a touch_key change to key_db = 2 + DEB_CYCLES cycles.
  - Glitches shorter than DEB_CYCLES are ignored.
- Press FSM (driven by key_db):
  - IDLE: key_db rising -> PRESSED, hold_cnt <= 0.
  - PRESSED: hold_cnt increments each cycle.
    - key_db falling before hold_cnt reaches LONG_CYCLES-1 -> IDLE. Short event: mode <= mode+1 (wraps 3->0), press_pulse <= 1 for exactly one cycle in the same cycle as the mode update.
    - hold_cnt == LONG_CYCLES-1 while key_db high -> LONG_HELD. Long event: mode <= 0, no press_pulse.
  - LONG_HELD: waits; key_db falling -> IDLE, no event.
  - hold_cnt saturates; it never wraps.
- LED generation (led registered, one cycle after mode):
  - mode 0: led = 0.
  - mode 1: led = 1.
  - mode 2/3: blink_cnt counts 0..HALF-1 (HALF = SLOW_HALF or FAST_HALF), then led toggles and blink_cnt <= 0.
- Any change of mode clears blink_cnt. Entering mode 2 or 3 forces led = 1 on the first cycle, so each blink phase starts high for a full HALF.
- Short event in the same cycle that hold_cnt hits LONG_CYCLES-1: the short press wins, because the falling edge is checked first.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

Optional Feature:
- Macro LED_ACTIVE_LOW_EN.
- When defined: the led port is the inverse of the internal LED state. Reset value of led = 1, and LED "on" drives 0. This suits the board's active-low LED wiring.
- When undefined: led = internal state, reset value 0, "on" drives 1.
- mode and press_pulse are unaffected either way.

Test Plan:
Bench parameters: DEB_CYCLES=4, LONG_CYCLES=20, SLOW_HALF=8, FAST_HALF=2.
1. Reset, then touch_key high 3 cycles, then low -> key_db stays 0, mode stays 0, press_pulse never asserts.
2. touch_key high 10 cycles, then low -> exactly one press_pulse; mode 0->1; led = 1 one cycle later.
3. Four short presses from reset -> mode sequence 1, 2, 3, 0 with four press_pulse strobes. In mode 2, led toggles every 8 cycles starting high; in mode 3, every 2 cycles; in mode 0, led = 0.
4. From mode 2, hold touch_key high 40 cycles -> mode = 0 when hold_cnt reaches 19; no press_pulse on release; led = 0.
5. In mode 3 mid-blink, assert rst for 1 cycle -> next cycle mode = 0, led = 0, press_pulse = 0, and the FSM ignores the still-high key until it is released and pressed again.
6. With LED_ACTIVE_LOW_EN defined, repeat scenario 2 -> led = 1 after reset, led = 0 once mode = 1.
